// File: rtl/alu_pkg.sv
// Shared decode types for the ALU issue path: operation codes, operand selects,
// immediate formats and the decoded-instruction record.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2
  } src1_sel_e;

  typedef enum logic {
    SRC2_RS2 = 1'b0,
    SRC2_IMM = 1'b1
  } src2_sel_e;

  // IMM_SH carries the 5-bit shift amount zero-extended, not the full I-field.
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_SH   = 3'd2,
    IMM_S    = 3'd3,
    IMM_B    = 3'd4,
    IMM_U    = 3'd5,
    IMM_J    = 3'd6
  } imm_fmt_e;

  typedef struct packed {
    alu_op_e     alu_ctrl;
    src1_sel_e   src1_sel;
    src2_sel_e   src2_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        is_branch;
    logic        is_jump;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_write;
    logic        illegal;
  } dec_t;

  function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_SH:  imm = {27'd0, instr[24:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'd0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational RV32I decoder producing ALU control, operand selects, register
// indices and immediate. Undecodable words yield an all-zero record with illegal set.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  alu_op_e   alu_op;
  src1_sel_e src1_sel;
  src2_sel_e src2_sel;
  imm_fmt_e  imm_fmt;
  logic      use_rs1;
  logic      use_rs2;
  logic      use_rd;
  logic      is_branch;
  logic      is_jump;
  logic      mem_rd;
  logic      mem_wr;
  logic      reg_write;
  logic      illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    alu_op    = ALU_ADD;
    src1_sel  = SRC1_RS1;
    src2_sel  = SRC2_IMM;
    imm_fmt   = IMM_NONE;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;

    case (opcode)
      OPC_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        use_rd    = 1'b1;
        reg_write = 1'b1;
        src2_sel  = SRC2_RS2;
        alu_op    = base_alu_op(funct3);
        // The alternate funct7 only exists for SUB and SRA.
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            alu_op = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            alu_op = ALU_SRA;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct7 != F7_BASE) begin
          illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        reg_write = 1'b1;
        imm_fmt   = IMM_I;
        alu_op    = base_alu_op(funct3);
        if (funct3 == 3'b001) begin
          imm_fmt = IMM_SH;
          if (funct7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end else if (funct3 == 3'b101) begin
          imm_fmt = IMM_SH;
          if (funct7 == F7_ALT) begin
            alu_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end
      end

      OPC_BRANCH: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        src2_sel  = SRC2_RS2;
        imm_fmt   = IMM_B;
        is_branch = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_BEQ;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          3'b110:  alu_op = ALU_BLTU;
          3'b111:  alu_op = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end

      OPC_LOAD: begin
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        reg_write = 1'b1;
        mem_rd    = 1'b1;
        imm_fmt   = IMM_I;
      end

      OPC_STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        mem_wr  = 1'b1;
        imm_fmt = IMM_S;
      end

      OPC_LUI: begin
        src1_sel  = SRC1_ZERO;
        use_rd    = 1'b1;
        reg_write = 1'b1;
        imm_fmt   = IMM_U;
      end

      OPC_AUIPC: begin
        src1_sel  = SRC1_PC;
        use_rd    = 1'b1;
        reg_write = 1'b1;
        imm_fmt   = IMM_U;
      end

      OPC_JAL: begin
        src1_sel  = SRC1_PC;
        use_rd    = 1'b1;
        reg_write = 1'b1;
        is_jump   = 1'b1;
        imm_fmt   = IMM_J;
      end

      OPC_JALR: begin
        use_rs1   = 1'b1;
        use_rd    = 1'b1;
        reg_write = 1'b1;
        is_jump   = 1'b1;
        imm_fmt   = IMM_I;
      end

      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec.illegal = illegal;
    if (!illegal) begin
      dec.alu_ctrl  = alu_op;
      dec.src1_sel  = src1_sel;
      dec.src2_sel  = src2_sel;
      dec.rs1       = use_rs1 ? instr[19:15] : 5'd0;
      dec.rs2       = use_rs2 ? instr[24:20] : 5'd0;
      dec.rd        = use_rd  ? instr[11:7]  : 5'd0;
      dec.imm       = gen_imm(instr, imm_fmt);
      dec.is_branch = is_branch;
      dec.is_jump   = is_jump;
      dec.mem_rd    = mem_rd;
      dec.mem_wr    = mem_wr;
      dec.reg_write = reg_write;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-to-execute issue stage: decodes one instruction per handshake into a
// single ID/EX register drained by the execute stage over valid/ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic [1:0]      out_src1_sel,
  output logic            out_src2_sel,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_reg_write,
  output logic            out_illegal
);

  dec_t            dec_w;
  dec_t            dec_q;
  dec_t            dec_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            valid_q;
  logic            valid_d;
  logic            accept;

  alu_ctrl_dec u_dec (
    .instr (in_instr),
    .dec   (dec_w)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Flush wins over everything: a beat accepted in the same cycle is dropped.
  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      dec_d   = dec_w;
      pc_d    = in_pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_alu_ctrl  = dec_q.alu_ctrl;
  assign out_src1_sel  = dec_q.src1_sel;
  assign out_src2_sel  = dec_q.src2_sel;
  assign out_rs1       = dec_q.rs1;
  assign out_rs2       = dec_q.rs2;
  assign out_rd        = dec_q.rd;
  assign out_imm       = dec_q.imm;
  assign out_pc        = pc_q;
  assign out_is_branch = dec_q.is_branch;
  assign out_is_jump   = dec_q.is_jump;
  assign out_mem_rd    = dec_q.mem_rd;
  assign out_mem_wr    = dec_q.mem_wr;
  assign out_reg_write = dec_q.reg_write;
  assign out_illegal   = dec_q.illegal;

endmodule
